fpu_sched: RTL and testbench
============================

FPU_SCHED -- requirements
Module: fpu_sched

Interface
REQ-001 Parameter ADD_LAT, default 2, FPU busy cycles for FADD.S/FSUB.S (range 1..15).
REQ-002 Parameter MUL_LAT, default 3, FPU busy cycles for FMUL.S (range 1..15).
REQ-003 Parameter DIV_LAT, default 12, FPU busy cycles for FDIV.S (range 1..15).
REQ-004 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port issue_valid, input, 1, decoder presents an FP R-type instruction (opcode 1010011) this cycle.
REQ-007 Port funct5, input, 5, instruction bits [31:27]: 00000 add, 00001 sub, 00010 mul, 00011 div.
REQ-008 Port rd, input, 5, FP destination register of the issuing instruction.
REQ-009 Port flush, input, 1, abort any in-flight operation (branch/jump redirect).
REQ-010 Port stall, output, 1, hold PC and fetch/decode registers this cycle.
REQ-011 Port fpu_start, output, 1, one-cycle launch pulse to the shared FPU.
REQ-012 Port fpu_op, output, 2, operation to the FPU: 00 add, 01 sub, 10 mul, 11 div.
REQ-013 Port fp_we, output, 1, FP register-file write enable.
REQ-014 Port wb_rd, output, 5, FP register-file write address.
REQ-015 Port illegal, output, 1, one-cycle pulse flagging an unsupported funct5.

Function
REQ-016 The block SHALL implement the FSM states IDLE, BUSY and WB.
REQ-017 An issue is legal when issue_valid=1 and funct5 is in 00000..00011; any other funct5 with issue_valid=1 is illegal.
REQ-018 In IDLE, a legal issue SHALL latch fpu_op=funct5[1:0] and wb_rd=rd, load cnt with LAT-1 for the op class, and move to BUSY.
REQ-019 stall SHALL be combinational: 1 in IDLE during a legal issue with flush=0, 1 in every BUSY cycle, 0 in WB and otherwise.
REQ-020 fpu_start SHALL be registered and equal 1 only in the first BUSY cycle.
REQ-021 In BUSY, cnt SHALL decrement each cycle; when cnt=0 the next state SHALL be WB.
REQ-022 cnt SHALL be 4 bits and never wrap; DIV_LAT=15 leaves no wrap headroom to exploit.
REQ-023 In WB, fp_we SHALL be 1 for exactly that cycle with wb_rd valid; the next state SHALL be IDLE.
REQ-024 issue_valid in WB SHALL be ignored; the core advances at the end of WB and re-presents the next instruction in IDLE.
REQ-025 Latency: issue cycle, then LAT BUSY cycles, then 1 WB cycle; stall is high for LAT+1 cycles.
REQ-026 An illegal issue in IDLE SHALL pulse illegal the next cycle, leave stall=0 and the state at IDLE, and start no FPU operation.
REQ-027 flush=1 SHALL force the next state to IDLE and cnt to 0, and suppress fp_we in the following cycle, from any state.
REQ-028 flush=1 together with a legal issue in IDLE SHALL drop the issue.
REQ-029 fpu_op and wb_rd SHALL hold their latched values from issue through WB.
REQ-030 fp_we, fpu_start, illegal, fpu_op and wb_rd SHALL be registered outputs.

Reset
REQ-031 reset=1 at a clock edge SHALL set state=IDLE, cnt=0, fpu_start=0, fpu_op=00, fp_we=0, wb_rd=0 and illegal=0.
REQ-032 reset SHALL take priority over flush and issue_valid.
REQ-033 A reset asserted mid-operation SHALL abandon the operation with no fp_we pulse.
REQ-034 stall SHALL be 0 during reset.

Verification
REQ-035 FADD.S (funct5=00000, rd=5), default parameters -> stall high cycles 0-2; fpu_start high cycle 1; fp_we=1 with wb_rd=5 in cycle 3; stall=0 in cycle 3.
REQ-036 FDIV.S (funct5=00011, rd=31) -> fpu_op=11; stall high cycles 0-12; fp_we only in cycle 13.
REQ-037 funct5=00100 with issue_valid=1 -> illegal=1 in cycle 1; stall, fpu_start and fp_we stay 0.
REQ-038 FMUL.S issued, then flush=1 in cycle 2 -> IDLE in cycle 3; no fp_we pulse; stall=0 from cycle 3.
REQ-039 Back-to-back FMUL.S rd=1 then FSUB.S rd=2 -> fp_we with wb_rd=1 in cycle 4; second issue accepted in cycle 5; fp_we with wb_rd=2 in cycle 8.
REQ-040 reset=1 in cycle 6 of an FDIV.S -> all outputs 0 in cycle 7; no fp_we afterwards.

Source files
------------

// File: rtl/fpu_sched_if.sv
// rtl/fpu_sched_if.sv - decoder/core to FP scheduler handshake bundle
//
// Purpose: groups the issue, flush and writeback signals between the core
// pipeline (master) and the FP scheduler (slave).
// Signals:
//   issue_valid, funct5[4:0], rd[4:0], flush  core -> scheduler
//   stall, fpu_start, fpu_op[1:0]             scheduler -> core / FPU
//   fp_we, wb_rd[4:0], illegal                scheduler -> core / FP regfile
interface fpu_sched_if;
  logic       issue_valid;
  logic [4:0] funct5;
  logic [4:0] rd;
  logic       flush;
  logic       stall;
  logic       fpu_start;
  logic [1:0] fpu_op;
  logic       fp_we;
  logic [4:0] wb_rd;
  logic       illegal;

  modport master (
    output issue_valid, funct5, rd, flush,
    input  stall, fpu_start, fpu_op, fp_we, wb_rd, illegal
  );

  modport slave (
    input  issue_valid, funct5, rd, flush,
    output stall, fpu_start, fpu_op, fp_we, wb_rd, illegal
  );
endinterface

// File: rtl/fpu_sched.sv
// rtl/fpu_sched.sv - single-issue scheduler for a shared multi-cycle FPU
//
// Purpose: accepts one FP R-type op at a time, stalls the front end while
// the FPU is busy, launches the FPU with a one-cycle pulse and issues a
// single-cycle FP register-file write when the latency has elapsed.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    fpu_sched_if.slave (issue/flush in; stall, fpu_start, fpu_op,
//          fp_we, wb_rd, illegal out)
module fpu_sched #(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 12
) (
  input  logic      clk,
  input  logic      reset,
  fpu_sched_if.slave bus
);

  // Counter preloads: BUSY lasts LAT cycles, counting LAT-1 down to 0.
  localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t     state, stateNext;
  logic [3:0] cnt, cntNext;
  logic       startQ, startNext;
  logic       weQ, weNext;
  logic       illegalQ, illegalNext;
  logic [1:0] opQ, opNext;
  logic [4:0] rdQ, rdNext;
  logic       stallComb;

  logic legalIssue;
  logic illegalIssue;

  assign legalIssue   = bus.issue_valid && (bus.funct5[4:2] == 3'b000);
  assign illegalIssue = bus.issue_valid && (bus.funct5[4:2] != 3'b000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      startQ   <= 1'b0;
      weQ      <= 1'b0;
      illegalQ <= 1'b0;
      opQ      <= 2'b00;
      rdQ      <= 5'd0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      startQ   <= startNext;
      weQ      <= weNext;
      illegalQ <= illegalNext;
      opQ      <= opNext;
      rdQ      <= rdNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    startNext   = 1'b0;
    weNext      = 1'b0;
    illegalNext = 1'b0;
    opNext      = opQ;
    rdNext      = rdQ;
    stallComb   = 1'b0;

    unique case (state)
      IDLE: begin
        // A redirect makes the presented instruction wrong-path: drop it
        // whether it is legal or not.
        if (!bus.flush) begin
          if (legalIssue) begin
            stallComb = 1'b1;
            opNext    = bus.funct5[1:0];
            rdNext    = bus.rd;
            startNext = 1'b1;
            stateNext = BUSY;
            unique case (bus.funct5[1:0])
              2'b10:   cntNext = MUL_CNT;
              2'b11:   cntNext = DIV_CNT;
              default: cntNext = ADD_CNT;
            endcase
          end else if (illegalIssue) begin
            illegalNext = 1'b1;
          end
        end
      end
      BUSY: begin
        stallComb = 1'b1;
        if (cnt == 4'd0) begin
          stateNext = WB;
          weNext    = 1'b1;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      WB: begin
        // Any issue shown here is the instruction just retired; ignore it.
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        cntNext   = 4'd0;
      end
    endcase

    if (bus.flush) begin
      stateNext = IDLE;
      cntNext   = 4'd0;
      startNext = 1'b0;
      weNext    = 1'b0;
    end

    if (reset) begin
      stallComb = 1'b0;
    end
  end

  assign bus.stall     = stallComb;
  assign bus.fpu_start = startQ;
  assign bus.fp_we     = weQ;
  assign bus.illegal   = illegalQ;
  assign bus.fpu_op    = opQ;
  assign bus.wb_rd     = rdQ;

endmodule

// File: tb/tb_fpu_sched.sv
// tb/tb_fpu_sched.sv - self-checking bench for fpu_sched
module tb_fpu_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  fpu_sched_if bus ();

  fpu_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  bit modelOn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Timeline model: an accepted op issued at cycle T with latency L is busy
  // in cycles T+1..T+L, launches in T+1 and writes back in T+L+1.
  bit         mActive = 1'b0;
  int         mIssueCyc = 0;
  int         mLat = 0;
  logic [1:0] mOp = 2'b00;
  logic [4:0] mRd = 5'd0;
  bit         mIll = 1'b0;

  function automatic int latOf(input logic [1:0] op);
    case (op)
      2'b10:   return 3;
      2'b11:   return 12;
      default: return 2;
    endcase
  endfunction

  always @(negedge clk) begin
    int ph;
    bit busy, wb, idle, legal;
    if (modelOn) begin
      ph    = cyc - mIssueCyc;
      busy  = mActive && ph >= 1 && ph <= mLat;
      wb    = mActive && ph == mLat + 1;
      idle  = !busy && !wb;
      legal = bus.issue_valid && (bus.funct5 < 5'd4);

      check("m_stall", 32'(bus.stall), 32'(!reset && (busy || (idle && legal && !bus.flush))));
      check("m_fpu_start", 32'(bus.fpu_start), 32'(mActive && ph == 1));
      check("m_fp_we", 32'(bus.fp_we), 32'(wb));
      check("m_wb_rd", 32'(bus.wb_rd), 32'(mRd));
      check("m_fpu_op", 32'(bus.fpu_op), 32'(mOp));
      check("m_illegal", 32'(bus.illegal), 32'(mIll));

      if (reset) begin
        mActive = 1'b0;
        mOp     = 2'b00;
        mRd     = 5'd0;
        mIll    = 1'b0;
      end else begin
        mIll = idle && bus.issue_valid && !legal && !bus.flush;
        if (bus.flush) begin
          mActive = 1'b0;
        end else if (idle && legal) begin
          mActive   = 1'b1;
          mIssueCyc = cyc;
          mOp       = bus.funct5[1:0];
          mRd       = bus.rd;
          mLat      = latOf(bus.funct5[1:0]);
        end else if (wb) begin
          mActive = 1'b0;
        end
      end
    end
  end

  task automatic tick(input logic v, input logic [4:0] f, input logic [4:0] r,
                      input logic fl, input logic rs);
    @(posedge clk);
    #1;
    bus.issue_valid = v;
    bus.funct5      = f;
    bus.rd          = r;
    bus.flush       = fl;
    reset           = rs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.issue_valid = 1'b0;
    bus.funct5      = 5'd0;
    bus.rd          = 5'd0;
    bus.flush       = 1'b0;

    // Reset
    tick(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    tick(1'b1, 5'd0, 5'd4, 1'b0, 1'b1);
    modelOn = 1'b1;
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_fpu_start", 32'(bus.fpu_start), 0);
    check("rst_fp_we", 32'(bus.fp_we), 0);
    check("rst_wb_rd", 32'(bus.wb_rd), 0);
    check("rst_fpu_op", 32'(bus.fpu_op), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    idle(2);

    // FADD.S rd=5
    tick(1'b1, 5'd0, 5'd5, 1'b0, 1'b0);
    check("add_stall_c0", 32'(bus.stall), 1);
    idle(1);
    check("add_start_c1", 32'(bus.fpu_start), 1);
    check("add_stall_c1", 32'(bus.stall), 1);
    idle(1);
    check("add_stall_c2", 32'(bus.stall), 1);
    check("add_start_c2", 32'(bus.fpu_start), 0);
    idle(1);
    check("add_we_c3", 32'(bus.fp_we), 1);
    check("add_wbrd_c3", 32'(bus.wb_rd), 5);
    check("add_stall_c3", 32'(bus.stall), 0);
    idle(2);

    // FDIV.S rd=31
    tick(1'b1, 5'd3, 5'd31, 1'b0, 1'b0);
    check("div_stall_c0", 32'(bus.stall), 1);
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      check("div_stall_busy", 32'(bus.stall), 1);
      check("div_we_busy", 32'(bus.fp_we), 0);
      if (i == 1) check("div_op_c1", 32'(bus.fpu_op), 3);
    end
    idle(1);
    check("div_we_c13", 32'(bus.fp_we), 1);
    check("div_stall_c13", 32'(bus.stall), 0);
    check("div_wbrd_c13", 32'(bus.wb_rd), 31);
    idle(2);

    // Illegal funct5=00100
    tick(1'b1, 5'd4, 5'd7, 1'b0, 1'b0);
    check("ill_stall_c0", 32'(bus.stall), 0);
    idle(1);
    check("ill_pulse_c1", 32'(bus.illegal), 1);
    check("ill_stall_c1", 32'(bus.stall), 0);
    check("ill_start_c1", 32'(bus.fpu_start), 0);
    check("ill_we_c1", 32'(bus.fp_we), 0);
    idle(1);
    check("ill_pulse_c2", 32'(bus.illegal), 0);
    idle(1);

    // FMUL.S then flush in cycle 2
    tick(1'b1, 5'd2, 5'd9, 1'b0, 1'b0);
    idle(1);
    tick(1'b0, 5'd0, 5'd0, 1'b1, 1'b0);
    check("fl_stall_c2", 32'(bus.stall), 1);
    idle(1);
    check("fl_stall_c3", 32'(bus.stall), 0);
    idle(1);
    check("fl_we_c4", 32'(bus.fp_we), 0);
    idle(1);
    check("fl_we_c5", 32'(bus.fp_we), 0);
    idle(1);

    // Back-to-back FMUL.S rd=1 (held while stalled) then FSUB.S rd=2
    tick(1'b1, 5'd2, 5'd1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) tick(1'b1, 5'd2, 5'd1, 1'b0, 1'b0);
    check("b2b_we_c4", 32'(bus.fp_we), 1);
    check("b2b_wbrd_c4", 32'(bus.wb_rd), 1);
    check("b2b_stall_c4", 32'(bus.stall), 0);
    tick(1'b1, 5'd1, 5'd2, 1'b0, 1'b0);
    check("b2b_stall_c5", 32'(bus.stall), 1);
    idle(1);
    check("b2b_start_c6", 32'(bus.fpu_start), 1);
    check("b2b_op_c6", 32'(bus.fpu_op), 1);
    idle(2);
    check("b2b_we_c8", 32'(bus.fp_we), 1);
    check("b2b_wbrd_c8", 32'(bus.wb_rd), 2);
    idle(2);

    // Flush together with a legal issue in IDLE
    tick(1'b1, 5'd0, 5'd3, 1'b1, 1'b0);
    check("fli_stall_c0", 32'(bus.stall), 0);
    idle(1);
    check("fli_start_c1", 32'(bus.fpu_start), 0);
    check("fli_stall_c1", 32'(bus.stall), 0);
    idle(1);

    // Reset in cycle 6 of FDIV.S
    tick(1'b1, 5'd3, 5'd17, 1'b0, 1'b0);
    idle(5);
    tick(1'b0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("rdiv_stall_c6", 32'(bus.stall), 0);
    idle(1);
    check("rdiv_stall_c7", 32'(bus.stall), 0);
    check("rdiv_start_c7", 32'(bus.fpu_start), 0);
    check("rdiv_we_c7", 32'(bus.fp_we), 0);
    check("rdiv_op_c7", 32'(bus.fpu_op), 0);
    check("rdiv_wbrd_c7", 32'(bus.wb_rd), 0);
    check("rdiv_illegal_c7", 32'(bus.illegal), 0);
    for (int i = 0; i < 14; i++) begin
      idle(1);
      check("rdiv_no_we", 32'(bus.fp_we), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
